// File: rtl/ece_bit_packer_pkg.sv
// Shared widths, addresses, FSM encoding and parity helper for the ECE bit packer.
// Optional feature macro: ECE_PACK_PARITY_EN (even-parity bit after every byte).
package ece_pkg;

    localparam int AW     = 15;
    localparam int BYTE_W = 8;

    localparam logic [AW-1:0] LEN_ADDR = 15'd32767;
    localparam logic [AW-1:0] MAX_BITS = 15'd32767;

    // Index of the final stream bit produced from one byte.
`ifdef ECE_PACK_PARITY_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LEN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic even_parity(input logic [BYTE_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ece_bit_packer_if.sv
// Byte-input handshake and stream-memory write port of the ECE bit packer.
interface ece_bit_packer_if;
    import ece_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [AW-1:0]     WAddr;
    logic [AW-1:0]     WData;
    logic              Wen;
    logic              Overflow;
    logic              Finish;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, WAddr, WData, Wen, Overflow, Finish
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, WAddr, WData, Wen, Overflow, Finish
    );

endinterface

// File: rtl/ece_bit_packer_byte_serializer.sv
// Holds the accepted byte and walks its bits LSB first (plus parity when ECE_PACK_PARITY_EN).
module ece_byte_serializer
    import ece_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [BYTE_W-1:0] data,
    input  logic              last,
    output logic              last_q,
    output logic              idx_last,
    output logic              idx_pre_last,
    output logic              next_bit
);

    logic [BYTE_W-1:0] shreg_r;
    logic [3:0]        idx_r;
    logic              last_r;

    // Byte register and index; idx_r names the bit most recently handed to the memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= 8'd0;
            idx_r   <= 4'd0;
            last_r  <= 1'b0;
        end else if (load) begin
            shreg_r <= data;
            idx_r   <= 4'd0;
            last_r  <= last;
        end else if (advance) begin
            idx_r   <= idx_r + 4'd1;
        end else begin
            idx_r   <= idx_r;
        end
    end

    assign last_q       = last_r;
    assign idx_last     = (idx_r == LAST_IDX);
    assign idx_pre_last = (idx_r == (LAST_IDX - 4'd1));

    // Bit that follows idx_r: the next data bit, or parity once all data bits are out.
    always_comb begin
        next_bit = shreg_r[idx_r[2:0] + 3'd1];
`ifdef ECE_PACK_PARITY_EN
        if (idx_r == 4'd7) begin
            next_bit = even_parity(shreg_r);
        end else begin
            next_bit = shreg_r[idx_r[2:0] + 3'd1];
        end
`endif
    end

endmodule

// File: rtl/ece_bit_packer.sv
// Serializes a byte frame into one-bit-per-word stream memory, then writes the bit count.
// Optional feature macro: ECE_PACK_PARITY_EN (handled in ece_pkg and ece_byte_serializer).
module ece_bit_packer
    import ece_pkg::*;
(
    input logic              clk,
    input logic              rst,
    ece_bit_packer_if.slave  bus
);

    state_t        state_r;
    logic [AW-1:0] count_r;
    logic [AW-1:0] waddr_r;
    logic [AW-1:0] wdata_r;
    logic          wen_r;
    logic          ready_r;
    logic          overflow_r;
    logic          finish_r;

    logic hs_s;
    logic take_bit_s;
    logic advance_s;
    logic bit_s;
    logic last_q_s;
    logic idx_last_s;
    logic idx_pre_last_s;
    logic next_bit_s;

    assign hs_s = bus.in_valid & ready_r;

    ece_byte_serializer u_ser (
        .clk          (clk),
        .rst          (rst),
        .load         (hs_s),
        .advance      (advance_s),
        .data         (bus.in_data),
        .last         (bus.in_last),
        .last_q       (last_q_s),
        .idx_last     (idx_last_s),
        .idx_pre_last (idx_pre_last_s),
        .next_bit     (next_bit_s)
    );

    // An accepted byte writes its bit 0 on the handshake edge, giving one-cycle latency.
    always_comb begin
        take_bit_s = 1'b0;
        advance_s  = 1'b0;
        case (state_r)
            IDLE:    take_bit_s = hs_s;
            SHIFT: begin
                take_bit_s = hs_s | ~idx_last_s;
                advance_s  = ~idx_last_s;
            end
            default: begin
                take_bit_s = 1'b0;
                advance_s  = 1'b0;
            end
        endcase
        if (hs_s) begin
            bit_s = bus.in_data[0];
        end else begin
            bit_s = next_bit_s;
        end
    end

    // Control FSM with registered memory port, bit count, sticky flags and ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= 15'd0;
            waddr_r    <= 15'd0;
            wdata_r    <= 15'd0;
            wen_r      <= 1'b0;
            ready_r    <= 1'b0;
            overflow_r <= 1'b0;
            finish_r   <= 1'b0;
        end else begin
            if (take_bit_s && (count_r != MAX_BITS)) begin
                wen_r   <= 1'b1;
                waddr_r <= count_r;
                wdata_r <= {14'd0, bit_s};
                count_r <= count_r + 15'd1;
            end else if ((state_r == SHIFT) && idx_last_s && last_q_s) begin
                wen_r   <= 1'b1;
                waddr_r <= LEN_ADDR;
                wdata_r <= count_r;
            end else begin
                wen_r   <= 1'b0;
            end

            // Saturated count: the bit is dropped and the loss is remembered.
            if (take_bit_s && (count_r == MAX_BITS)) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end

            case (state_r)
                IDLE: begin
                    ready_r <= ~hs_s;
                    if (hs_s) begin
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (!idx_last_s) begin
                        ready_r <= idx_pre_last_s & ~last_q_s;
                    end else if (last_q_s) begin
                        ready_r <= 1'b0;
                        state_r <= LEN;
                    end else begin
                        ready_r <= ~hs_s;
                    end
                end
                LEN: begin
                    ready_r  <= 1'b0;
                    finish_r <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    ready_r  <= 1'b0;
                    finish_r <= 1'b1;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = ready_r;
    assign bus.WAddr    = waddr_r;
    assign bus.WData    = wdata_r;
    assign bus.Wen      = wen_r;
    assign bus.Overflow = overflow_r;
    assign bus.Finish   = finish_r;

endmodule
